rtc_calendar_bcd: RTL and testbench

- Clocked BCD calendar: day, month, 4-digit year and weekday.
- Advances on a one-cycle day_tick pulse, issued by the time-of-day block at its 23:59:59 -> 00:00:00 rollover.
- Adds Gregorian leap years (including the century rule), a configurable year window with wrap-around, and a validated load handshake.
- Feeds the display/bus layer through the packed full_cal word.

---
 rtl/rtc_cal_pkg.sv | 63 ++++++
 rtl/rtc_days_in_month.sv | 26 ++
 rtl/rtc_calendar_bcd.sv | 136 +++++++++++++
 tb/tb_rtc_calendar_bcd.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_cal_pkg.sv
// Shared types, BCD constants and digit helpers for the BCD calendar.
// Pure package: no state, no latency, no flow control.
package rtc_cal_pkg;

   typedef enum logic [1:0] {IDLE, CHECK, WAIT_DROP} load_state_t;

   localparam logic [7:0] M_JAN = 8'h01;
   localparam logic [7:0] M_FEB = 8'h02;
   localparam logic [7:0] M_MAR = 8'h03;
   localparam logic [7:0] M_APR = 8'h04;
   localparam logic [7:0] M_MAY = 8'h05;
   localparam logic [7:0] M_JUN = 8'h06;
   localparam logic [7:0] M_JUL = 8'h07;
   localparam logic [7:0] M_AUG = 8'h08;
   localparam logic [7:0] M_SEP = 8'h09;
   localparam logic [7:0] M_OCT = 8'h10;
   localparam logic [7:0] M_NOV = 8'h11;
   localparam logic [7:0] M_DEC = 8'h12;

   localparam logic [3:0] WD_MON = 4'd1;
   localparam logic [3:0] WD_TUE = 4'd2;
   localparam logic [3:0] WD_WED = 4'd3;
   localparam logic [3:0] WD_THU = 4'd4;
   localparam logic [3:0] WD_FRI = 4'd5;
   localparam logic [3:0] WD_SAT = 4'd6;
   localparam logic [3:0] WD_SUN = 4'd7;

   // Divisibility by 4 of a two-digit BCD value, read straight off the digits.
   function automatic logic bcd_div4(input logic [7:0] xy);
      if (!xy[4])
         return (xy[3:0] == 4'd0) || (xy[3:0] == 4'd4) || (xy[3:0] == 4'd8);
      return (xy[3:0] == 4'd2) || (xy[3:0] == 4'd6);
   endfunction

   function automatic logic bcd_ok8(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
   endfunction

   function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Length of a BCD month in BCD days, Gregorian leap rule optional.
// Purely combinational, no flow control.
module rtc_days_in_month
   import rtc_cal_pkg::*;
(
   input  logic [7:0]  month,
   input  logic [15:0] year,
   input  logic        leap_en,
   output logic [7:0]  days
);

   logic leap;

   always_comb begin
      // Century years fall back to the high digits: 2000 is leap, 2100 is not.
      leap = (year[7:0] != 8'h00) ? bcd_div4(year[7:0]) : bcd_div4(year[15:8]);
      days = 8'h31;
      case (month)
         M_JAN, M_MAR, M_MAY, M_JUL, M_AUG, M_OCT, M_DEC: days = 8'h31;
         M_APR, M_JUN, M_SEP, M_NOV:                      days = 8'h30;
         M_FEB:  days = (leap_en && leap) ? 8'h29 : 8'h28;
         default: days = 8'h31;
      endcase
   end

endmodule

// File: rtl/rtc_calendar_bcd.sv
// BCD calendar advanced by day_tick (latency 1); loads via set_req held until set_ack.
// A valid load applied in CHECK wins over a coincident day_tick, which is dropped.
module rtc_calendar_bcd
   import rtc_cal_pkg::*;
#(
   parameter logic [15:0] YEAR_MIN      = 16'h2000,
   parameter logic [15:0] YEAR_MAX      = 16'h2099,
   parameter logic [3:0]  RESET_WEEKDAY = 4'd6,
   parameter bit          LEAP_EN       = 1'b1
) (
   input  logic        d_clk,
   input  logic        rst,
   input  logic        day_tick,
   input  logic        set_req,
   input  logic [7:0]  set_day,
   input  logic [7:0]  set_month,
   input  logic [15:0] set_year,
   input  logic [3:0]  set_weekday,
   output logic        set_ack,
   output logic        set_err,
   output logic [7:0]  real_day,
   output logic [7:0]  real_month,
   output logic [15:0] real_year,
   output logic [3:0]  real_weekday,
   output logic [35:0] full_cal,
   output logic        month_end,
   output logic        year_wrap
);

   load_state_t state;
   logic [7:0]  sh_day;
   logic [7:0]  sh_month;
   logic [15:0] sh_year;
   logic [3:0]  sh_weekday;
   logic [7:0]  live_dim;
   logic [7:0]  set_dim;
   logic        set_valid;

   rtc_days_in_month u_dim_live (
      .month   (real_month),
      .year    (real_year),
      .leap_en (LEAP_EN),
      .days    (live_dim)
   );

   rtc_days_in_month u_dim_set (
      .month   (sh_month),
      .year    (sh_year),
      .leap_en (LEAP_EN),
      .days    (set_dim)
   );

   // With every nibble a decimal digit, unsigned compares order BCD values correctly.
   always_comb begin
      set_valid = bcd_ok8(sh_day) && bcd_ok8(sh_month)
               && bcd_ok8(sh_year[15:8]) && bcd_ok8(sh_year[7:0])
               && (sh_month >= M_JAN) && (sh_month <= M_DEC)
               && (sh_day != 8'h00) && (sh_day <= set_dim)
               && (sh_weekday >= WD_MON) && (sh_weekday <= WD_SUN)
               && (sh_year >= YEAR_MIN) && (sh_year <= YEAR_MAX);
   end

   assign full_cal = {real_day, real_weekday, real_month, real_year};

   always_ff @(posedge d_clk) begin
      if (rst) begin
         state        <= IDLE;
         sh_day       <= 8'h01;
         sh_month     <= M_JAN;
         sh_year      <= YEAR_MIN;
         sh_weekday   <= RESET_WEEKDAY;
         real_day     <= 8'h01;
         real_month   <= M_JAN;
         real_year    <= YEAR_MIN;
         real_weekday <= RESET_WEEKDAY;
         set_ack      <= 1'b0;
         set_err      <= 1'b0;
         month_end    <= 1'b0;
         year_wrap    <= 1'b0;
      end else begin
         set_ack   <= 1'b0;
         set_err   <= 1'b0;
         month_end <= 1'b0;
         year_wrap <= 1'b0;

         case (state)
            IDLE: begin
               if (set_req) begin
                  sh_day     <= set_day;
                  sh_month   <= set_month;
                  sh_year    <= set_year;
                  sh_weekday <= set_weekday;
                  state      <= CHECK;
               end
            end
            CHECK: begin
               set_ack <= 1'b1;
               set_err <= !set_valid;
               state   <= WAIT_DROP;
            end
            WAIT_DROP: begin
               if (!set_req)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if ((state == CHECK) && set_valid) begin
            real_day     <= sh_day;
            real_month   <= sh_month;
            real_year    <= sh_year;
            real_weekday <= sh_weekday;
         end else if (day_tick) begin
            real_weekday <= (real_weekday == WD_SUN) ? WD_MON : real_weekday + 4'd1;
            if (real_day == live_dim) begin
               real_day  <= 8'h01;
               month_end <= 1'b1;
               if (real_month == M_DEC) begin
                  real_month <= M_JAN;
                  if (real_year == YEAR_MAX) begin
                     real_year <= YEAR_MIN;
                     year_wrap <= 1'b1;
                  end else begin
                     real_year <= bcd_inc16(real_year);
                  end
               end else begin
                  real_month <= bcd_inc8(real_month);
               end
            end else begin
               real_day <= bcd_inc8(real_day);
            end
         end
      end
   end

endmodule

// File: tb/tb_rtc_calendar_bcd.sv
// Scoreboard bench: driver updates an integer-date model and queues expectations,
// a negedge monitor pops them on their due cycle and compares with the DUT.
module tb_rtc_calendar_bcd;

   localparam int Y_MIN = 2000;
   localparam int Y_MAX = 2099;

   logic        d_clk = 1'b0;
   logic        rst = 1'b1;
   logic        day_tick = 1'b0;
   logic        set_req = 1'b0;
   logic [7:0]  set_day = 8'h01;
   logic [7:0]  set_month = 8'h01;
   logic [15:0] set_year = 16'h2000;
   logic [3:0]  set_weekday = 4'd1;
   logic        set_ack, set_err, month_end, year_wrap;
   logic [7:0]  real_day, real_month;
   logic [15:0] real_year;
   logic [3:0]  real_weekday;
   logic [35:0] full_cal;

   logic        c_tick = 1'b0;
   logic        c_req = 1'b0;
   logic [7:0]  c_day = 8'h01;
   logic [7:0]  c_month = 8'h01;
   logic [15:0] c_year = 16'h2000;
   logic [3:0]  c_wd = 4'd1;
   logic        c_ack, c_err, c_me, c_yw;
   logic [7:0]  c_rday, c_rmonth;
   logic [15:0] c_ryear;
   logic [3:0]  c_rwd;
   logic [35:0] c_full;

   always #5 d_clk = ~d_clk;

   rtc_calendar_bcd dut (
      .d_clk(d_clk), .rst(rst), .day_tick(day_tick), .set_req(set_req),
      .set_day(set_day), .set_month(set_month), .set_year(set_year),
      .set_weekday(set_weekday), .set_ack(set_ack), .set_err(set_err),
      .real_day(real_day), .real_month(real_month), .real_year(real_year),
      .real_weekday(real_weekday), .full_cal(full_cal),
      .month_end(month_end), .year_wrap(year_wrap)
   );

   rtc_calendar_bcd #(.YEAR_MAX(16'h2199)) dut_c (
      .d_clk(d_clk), .rst(rst), .day_tick(c_tick), .set_req(c_req),
      .set_day(c_day), .set_month(c_month), .set_year(c_year),
      .set_weekday(c_wd), .set_ack(c_ack), .set_err(c_err),
      .real_day(c_rday), .real_month(c_rmonth), .real_year(c_ryear),
      .real_weekday(c_rwd), .full_cal(c_full),
      .month_end(c_me), .year_wrap(c_yw)
   );

   typedef struct {
      int          stamp;
      logic [7:0]  day;
      logic [7:0]  mon;
      logic [15:0] year;
      logic [3:0]  wd;
      bit          ack, err, me, yw;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   m_day, m_mon, m_year, m_wd;

   always @(posedge d_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit is_leap(input int y);
      return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
   endfunction

   function automatic int dim(input int m, input int y);
      case (m)
         2:           return is_leap(y) ? 29 : 28;
         4, 6, 9, 11: return 30;
         default:     return 31;
      endcase
   endfunction

   function automatic logic [7:0] bcd2(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [15:0] bcd4(input int v);
      return {bcd2(v / 100), bcd2(v % 100)};
   endfunction

   function automatic int bin2(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit model_valid(input logic [7:0] d, input logic [7:0] m,
                                      input logic [15:0] y, input logic [3:0] w);
      int di, mi, yi;
      for (int i = 0; i < 2; i++)
         if (d[i*4 +: 4] > 4'd9 || m[i*4 +: 4] > 4'd9) return 1'b0;
      for (int i = 0; i < 4; i++)
         if (y[i*4 +: 4] > 4'd9) return 1'b0;
      di = bin2(d);
      mi = bin2(m);
      yi = bin2(y[15:8]) * 100 + bin2(y[7:0]);
      if (mi < 1 || mi > 12) return 1'b0;
      if (yi < Y_MIN || yi > Y_MAX) return 1'b0;
      if (di < 1 || di > dim(mi, yi)) return 1'b0;
      return (w >= 4'd1) && (w <= 4'd7);
   endfunction

   task automatic model_reset();
      m_day = 1; m_mon = 1; m_year = Y_MIN; m_wd = 6;
   endtask

   task automatic model_tick(output bit me, output bit yw);
      me = 1'b0;
      yw = 1'b0;
      m_wd = (m_wd == 7) ? 1 : m_wd + 1;
      if (m_day == dim(m_mon, m_year)) begin
         m_day = 1;
         me = 1'b1;
         if (m_mon == 12) begin
            m_mon = 1;
            if (m_year == Y_MAX) begin
               m_year = Y_MIN;
               yw = 1'b1;
            end else begin
               m_year++;
            end
         end else begin
            m_mon++;
         end
      end else begin
         m_day++;
      end
   endtask

   task automatic push(input bit ack, input bit err, input bit me, input bit yw);
      exp_t e;
      e.stamp = cyc + 1;
      e.day = bcd2(m_day);
      e.mon = bcd2(m_mon);
      e.year = bcd4(m_year);
      e.wd = 4'(m_wd);
      e.ack = ack; e.err = err; e.me = me; e.yw = yw;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge d_clk);
      #1;
   endtask

   task automatic run_cycle(input bit tk, input bit req);
      bit me, yw;
      day_tick = tk;
      set_req = req;
      me = 1'b0; yw = 1'b0;
      if (tk) model_tick(me, yw);
      push(1'b0, 1'b0, me, yw);
      step();
   endtask

   // Capture then CHECK; the set_* bus is scrambled during CHECK to prove the shadow copy is used.
   task automatic load_front(input logic [7:0] d, input logic [7:0] m, input logic [15:0] y,
                             input logic [3:0] w, input bit tk1, input bit tk2);
      bit me, yw, v;
      set_day = d; set_month = m; set_year = y; set_weekday = w;
      set_req = 1'b1;
      day_tick = tk1;
      me = 1'b0; yw = 1'b0;
      if (tk1) model_tick(me, yw);
      push(1'b0, 1'b0, me, yw);
      step();
      set_day = 8'($urandom); set_month = 8'($urandom);
      set_year = 16'($urandom); set_weekday = 4'($urandom);
      day_tick = tk2;
      v = model_valid(d, m, y, w);
      me = 1'b0; yw = 1'b0;
      if (v) begin
         m_day = bin2(d); m_mon = bin2(m);
         m_year = bin2(y[15:8]) * 100 + bin2(y[7:0]);
         m_wd = int'(w);
      end else if (tk2) begin
         model_tick(me, yw);
      end
      push(1'b1, !v, me, yw);
      step();
   endtask

   task automatic do_load(input logic [7:0] d, input logic [7:0] m, input logic [15:0] y,
                          input logic [3:0] w, input bit tk1, input bit tk2, input int hold);
      load_front(d, m, y, w, tk1, tk2);
      for (int i = 0; i < hold; i++) run_cycle(1'($urandom_range(0, 1)), 1'b1);
      run_cycle(1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic random_load();
      int y, m, d, r;
      r = $urandom_range(0, 5);
      y = $urandom_range(Y_MIN, Y_MAX);
      m = $urandom_range(1, 12);
      d = $urandom_range(1, dim(m, y));
      if (r == 0) begin
         m = 12; d = 31;
         if ($urandom_range(0, 1) == 1) y = Y_MAX;
      end else if (r == 1) begin
         m = 2; d = $urandom_range(27, 30);
      end else if (r == 2) begin
         d = dim(m, y);
      end else if (r == 3) begin
         y = ($urandom_range(0, 1) == 1) ? $urandom_range(2100, 2199) : $urandom_range(1900, 1999);
      end
      if (r == 4)
         do_load(8'($urandom), 8'($urandom), 16'($urandom), 4'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      else
         do_load(bcd2(d), bcd2(m), bcd4(y), 4'($urandom_range(0, 8)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
   endtask

   task automatic c_load(input logic [7:0] d, input logic [7:0] m, input logic [15:0] y,
                         input bit exp_err);
      c_day = d; c_month = m; c_year = y; c_wd = 4'd1; c_req = 1'b1;
      step();
      step();
      check("c_load_ack", 64'({c_ack, c_ack & c_err}), 64'({1'b1, exp_err}));
      c_req = 1'b0;
      step();
   endtask

   always @(negedge d_clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
         check("missed_expectation", 64'(exp_q[0].stamp), 64'(cyc));
         void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
         e = exp_q.pop_front();
         check("date", 64'({real_day, real_month, real_year, real_weekday}),
               64'({e.day, e.mon, e.year, e.wd}));
         check("full_cal", 64'(full_cal), 64'({e.day, e.wd, e.mon, e.year}));
         check("flags", 64'({set_ack, set_ack & set_err, month_end, year_wrap}),
               64'({e.ack, e.err, e.me, e.yw}));
      end else if (set_ack === 1'b1) begin
         check("unexpected_ack", 64'(set_ack), 64'(0));
      end
   end

   initial begin
      model_reset();
      rst = 1'b1;
      push(1'b0, 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b0;

      run_cycle(1'b1, 1'b0);
      run_cycle(1'b0, 1'b0);

      do_load(8'h28, 8'h02, 16'h2024, 4'd3, 1'b0, 1'b0, 0);
      run_cycle(1'b1, 1'b0);
      run_cycle(1'b1, 1'b0);
      run_cycle(1'b0, 1'b0);

      do_load(8'h28, 8'h02, 16'h2000, 4'd1, 1'b0, 1'b0, 0);
      run_cycle(1'b1, 1'b0);

      do_load(8'h31, 8'h12, 16'h2099, 4'd4, 1'b0, 1'b0, 1);
      run_cycle(1'b1, 1'b0);
      run_cycle(1'b0, 1'b0);

      do_load(8'h29, 8'h02, 16'h2023, 4'd1, 1'b0, 1'b0, 0);
      do_load(8'h10, 8'h1A, 16'h2024, 4'd1, 1'b0, 1'b0, 0);
      do_load(8'h01, 8'h06, 16'h1999, 4'd1, 1'b0, 1'b0, 0);
      do_load(8'h10, 8'h05, 16'h2030, 4'd2, 1'b0, 1'b1, 2);
      do_load(8'h32, 8'h01, 16'h2030, 4'd1, 1'b1, 1'b1, 0);

      // Reset while the load FSM sits in WAIT_DROP with set_req still high.
      load_front(8'h15, 8'h07, 16'h2045, 4'd2, 1'b0, 1'b0);
      rst = 1'b1;
      set_req = 1'b1;
      day_tick = 1'b1;
      model_reset();
      push(1'b0, 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      run_cycle(1'b0, 1'b0);
      run_cycle(1'b0, 1'b0);

      repeat (300) begin
         if ($urandom_range(0, 9) < 7) run_cycle(1'($urandom_range(0, 1)), 1'b0);
         else random_load();
      end
      repeat (420) run_cycle(1'b1, 1'b0);
      do_load(8'h31, 8'h12, 16'h2099, 4'd7, 1'b0, 1'b0, 0);
      repeat (3) run_cycle(1'b1, 1'b0);

      day_tick = 1'b0;
      set_req = 1'b0;
      c_load(8'h28, 8'h02, 16'h2100, 1'b0);
      c_tick = 1'b1;
      step();
      c_tick = 1'b0;
      check("c_2100_feb_end", 64'({c_rday, c_rmonth, c_ryear, c_me}),
            64'({8'h01, 8'h03, 16'h2100, 1'b1}));
      c_load(8'h29, 8'h02, 16'h2100, 1'b1);
      c_load(8'h29, 8'h02, 16'h2000, 1'b0);
      check("c_2000_feb29", 64'({c_rday, c_rmonth, c_ryear}), 64'({8'h29, 8'h02, 16'h2000}));

      repeat (3) step();
      check("queue_drain", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
